// File: rtl/mips_stack_pkg.sv
// Shared types and sizing helpers for the MIPS hardware stack.
package mips_stack_pkg;

  localparam int unsigned STACK_WIDTH_DEF = 32;
  localparam int unsigned STACK_DEPTH_DEF = 16;

  // Operation code formed directly from {Push, Pop}
  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } op_e;

  // Address width of the (depth-1)-entry spill array, never below one bit
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth <= 3) ? 1 : $clog2(depth - 1);
  endfunction

endpackage

// File: rtl/mips_hw_stack_if.sv
// Memory-stage push/pop bus between the MIPS core and its hardware stack.
interface mips_hw_stack_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) ();

  logic             Push;
  logic             Pop;
  logic [WIDTH-1:0] WriteData;
  logic             ErrClr;
  logic [WIDTH-1:0] StackReadData;
  logic             Full;
  logic             Empty;
  logic [CNT_W-1:0] Count;
  logic             Overflow;
  logic             Underflow;

  modport master (
    output Push, Pop, WriteData, ErrClr,
    input  StackReadData, Full, Empty, Count, Overflow, Underflow
  );

  modport slave (
    input  Push, Pop, WriteData, ErrClr,
    output StackReadData, Full, Empty, Count, Overflow, Underflow
  );

endinterface

// File: rtl/mips_stack_ram.sv
// Spill array below top-of-stack: synchronous write, asynchronous read.
module mips_stack_ram #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ENTRIES = 15,
  parameter int unsigned AW      = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [ENTRIES];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mips_hw_stack.sv
// Hardware return/data stack for the MIPS memory stage, top held in a register.
// Optional sticky error flags enabled by defining MIPS_STACK_FLAG_EN.
module mips_hw_stack
  import mips_stack_pkg::*;
#(
  parameter int unsigned WIDTH = STACK_WIDTH_DEF,
  parameter int unsigned DEPTH = STACK_DEPTH_DEF,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic            CLK,
  input  logic            RST,
  mips_hw_stack_if.slave  bus
);

  localparam int unsigned AW = ptr_w(DEPTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic             we_c;
  logic [AW-1:0]    waddr_c, raddr_c;
  logic [WIDTH-1:0] rdata_c;
  logic             empty_c, full_c;
  logic             ovf_set_c, udf_set_c;
  op_e              op_c;

  assign empty_c = (cnt_q == '0);
  assign full_c  = (cnt_q == CNT_W'(DEPTH));
  assign op_c    = op_e'({bus.Push, bus.Pop});
  assign waddr_c = AW'(cnt_q - CNT_W'(1));
  assign raddr_c = (cnt_q >= CNT_W'(2)) ? AW'(cnt_q - CNT_W'(2)) : '0;

  mips_stack_ram #(
    .WIDTH   (WIDTH),
    .ENTRIES (DEPTH - 1),
    .AW      (AW)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (we_c),
    .waddr_i (waddr_c),
    .wdata_i (top_q),
    .raddr_i (raddr_c),
    .rdata_o (rdata_c)
  );

  // Next-state for top/count and error detection
  always_comb begin
    cnt_d     = cnt_q;
    top_d     = top_q;
    we_c      = 1'b0;
    ovf_set_c = 1'b0;
    udf_set_c = 1'b0;
    unique case (op_c)
      OP_PUSH: begin
        if (full_c) begin
          ovf_set_c = 1'b1;
        end else begin
          we_c  = !empty_c;
          top_d = bus.WriteData;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      OP_POP: begin
        if (empty_c) begin
          udf_set_c = 1'b1;
        end else begin
          top_d = rdata_c;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      OP_REPLACE: begin
        top_d = bus.WriteData;
        if (empty_c) begin
          udf_set_c = 1'b1;
          cnt_d     = CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q <= '0;
      top_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      top_q <= top_d;
    end
  end

`ifdef MIPS_STACK_FLAG_EN
  logic ovf_q, udf_q;

  // Clear wins over a same-cycle error
  always_ff @(posedge CLK) begin
    if (!RST || bus.ErrClr) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ovf_set_c) ovf_q <= 1'b1;
      if (udf_set_c) udf_q <= 1'b1;
    end
  end

  assign bus.Overflow  = ovf_q;
  assign bus.Underflow = udf_q;
`else
  logic unused_c;
  assign unused_c      = ^{bus.ErrClr, ovf_set_c, udf_set_c};
  assign bus.Overflow  = 1'b0;
  assign bus.Underflow = 1'b0;
`endif

  assign bus.StackReadData = empty_c ? '0 : top_q;
  assign bus.Full          = full_c;
  assign bus.Empty         = empty_c;
  assign bus.Count         = cnt_q;

endmodule
